// File: rtl/la_aoi_pipe.sv
// rtl/la_aoi_pipe.sv - pipelined AOI/OAI gate array with valid/ready flow control
// Define LA_AOI_PIPE_COUNT_EN to enable the saturating accepted-beat counter on count.
module la_aoi_pipe #(
  parameter int WIDTH  = 8,
  parameter int GROUPS = 2,
  parameter int TERMS  = 3,
  parameter int STAGES = 2,
  parameter     MODE   = "AOI",
  parameter     PROP   = "DEFAULT"
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [GROUPS*TERMS*WIDTH-1:0]   in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                z,
  output logic [15:0]                     count
);

  logic [WIDTH-1:0]  f;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  data [STAGES];

  generate
    if (MODE == "AOI") begin : g_aoi
      always_comb begin
        logic [WIDTH-1:0] grp;
        logic [WIDTH-1:0] acc;
        acc = '0;
        grp = '1;
        for (int g = 0; g < GROUPS; g++) begin
          grp = '1;
          for (int t = 0; t < TERMS; t++)
            grp = grp & in[(g*TERMS+t)*WIDTH +: WIDTH];
          acc = acc | grp;
        end
        f = ~acc;
      end
    end else if (MODE == "OAI") begin : g_oai
      always_comb begin
        logic [WIDTH-1:0] grp;
        logic [WIDTH-1:0] acc;
        acc = '1;
        grp = '0;
        for (int g = 0; g < GROUPS; g++) begin
          grp = '0;
          for (int t = 0; t < TERMS; t++)
            grp = grp | in[(g*TERMS+t)*WIDTH +: WIDTH];
          acc = acc & grp;
        end
        f = ~acc;
      end
    end else begin : g_bad_mode
      $error("la_aoi_pipe: MODE must be \"AOI\" or \"OAI\"");
      assign f = '0;
    end

    // Property string is only carried for the technology flow; no logic depends on it.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end
  endgenerate

  // A stage can load when any stage at or after it is empty, or the consumer takes a beat.
  always_comb begin
    logic r;
    r = out_ready;
    ready = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      r = r | ~valid[k];
      ready[k] = r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int k = 0; k < STAGES; k++)
        data[k] <= '0;
    end else begin
      if (ready[0]) begin
        valid[0] <= in_valid;
        data[0]  <= f;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid[k] <= valid[k-1];
          data[k]  <= data[k-1];
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid[STAGES-1];
  assign z         = data[STAGES-1];

`ifdef LA_AOI_PIPE_COUNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= 16'h0000;
    else if (in_valid && ready[0] && cnt != 16'hFFFF)
      cnt <= cnt + 16'h0001;
  end

  assign count = cnt;
`else
  assign count = 16'h0000;
`endif

endmodule

// File: tb/tb_la_aoi_pipe.sv
// tb/tb_la_aoi_pipe.sv - scoreboard bench for la_aoi_pipe, AOI and OAI instances driven in lockstep
module tb_la_aoi_pipe;
  localparam int W = 4;
  localparam int G = 2;
  localparam int T = 3;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             out_ready;
  logic [G*T*W-1:0] in_d;
  logic             in_ready_a, in_ready_o;
  logic             out_valid_a, out_valid_o;
  logic [W-1:0]     z_a, z_o;
  logic [15:0]      count_a, count_o;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] o;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  longint acc_cnt = 0;

  la_aoi_pipe #(.WIDTH(W), .GROUPS(G), .TERMS(T), .STAGES(S), .MODE("AOI")) dut_aoi (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in(in_d),
    .out_valid(out_valid_a), .out_ready(out_ready), .z(z_a), .count(count_a)
  );

  la_aoi_pipe #(.WIDTH(W), .GROUPS(G), .TERMS(T), .STAGES(S), .MODE("OAI")) dut_oai (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o), .in(in_d),
    .out_valid(out_valid_o), .out_ready(out_ready), .z(z_o), .count(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: AOI bit is 0 iff some group has every term high; OAI bit is 1 iff some group has every term low.
  function automatic logic [3:0] model(input logic [23:0] d, input bit oai);
    logic [3:0] r;
    int full_groups, empty_groups, ones;
    r = '0;
    for (int i = 0; i < W; i++) begin
      full_groups = 0;
      empty_groups = 0;
      for (int g = 0; g < G; g++) begin
        ones = 0;
        for (int t = 0; t < T; t++)
          ones += int'(d[(g*T+t)*W+i]);
        if (ones == T) full_groups++;
        if (ones == 0) empty_groups++;
      end
      r[i] = oai ? (empty_groups > 0) : (full_groups == 0);
    end
    return r;
  endfunction

  function automatic exp_t mexp(input logic [23:0] d);
    return {model(d, 1'b0), model(d, 1'b1)};
  endfunction

  function automatic logic [23:0] pack6(input logic [3:0] g0t0, g0t1, g0t2, g1t0, g1t1, g1t2);
    return {g1t2, g1t1, g1t0, g0t2, g0t1, g0t0};
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef LA_AOI_PIPE_COUNT_EN
    return (acc_cnt > 65535) ? 16'hFFFF : 16'(acc_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic cycle(input bit v, input logic [23:0] d, input bit ordy, input exp_t e, output bit accepted);
    @(negedge clk);
    in_valid = v;
    in_d = d;
    out_ready = ordy;
    #1;
    accepted = v && in_ready_a && !reset;
    if (accepted) begin
      sb.push_back(e);
      acc_cnt++;
    end
  endtask

  task automatic drain();
    bit acc;
    int budget;
    budget = 0;
    while ((sb.size() != 0 || out_valid_a) && budget < 20) begin
      cycle(1'b0, 24'($urandom), 1'b1, '0, acc);
      budget++;
    end
    check("drain_left", sb.size(), 0);
    cycle(1'b0, 24'($urandom), 1'b1, '0, acc);
    check("drain_out_valid", out_valid_a, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_ready && out_valid_a) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("z_aoi", z_a, e.a);
          check("z_oai", z_o, e.o);
          check("oai_valid", out_valid_o, 1);
        end
      end
    end
  end

  initial begin : stim
    bit acc;
    int sent, budget;
    logic [23:0] d, bpd [6];

    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_d = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_z_aoi", z_a, 0);
    check("rst_z_oai", z_o, 0);
    check("rst_count", count_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    acc_cnt = 0;

    d = pack6(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    cycle(1'b1, d, 1'b1, {4'h0, model(d, 1'b1)}, acc);
    check("dir1_acc", acc, 1);
    d = pack6(4'hA, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1);
    cycle(1'b1, d, 1'b1, {4'h4, model(d, 1'b1)}, acc);
    check("dir2_acc", acc, 1);
    d = pack6(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
    cycle(1'b1, d, 1'b1, {model(d, 1'b0), 4'hF}, acc);
    check("dir3_acc", acc, 1);
    d = pack6(4'h1, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0);
    cycle(1'b1, d, 1'b1, {model(d, 1'b0), 4'hE}, acc);
    check("dir4_acc", acc, 1);
    drain();

    d = 24'($urandom);
    cycle(1'b1, d, 1'b1, mexp(d), acc);
    cycle(1'b0, 24'($urandom), 1'b1, '0, acc);
    check("lat_early", out_valid_a, 0);
    cycle(1'b0, 24'($urandom), 1'b1, '0, acc);
    check("lat_due", out_valid_a, 1);
    drain();

    for (int i = 0; i < 6; i++) bpd[i] = 24'($urandom);
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, bpd[sent], 1'b0, mexp(bpd[sent]), acc);
      if (acc) sent++;
    end
    check("bp_accepts_full", sent, S);
    check("bp_in_ready", in_ready_a, 0);
    budget = 0;
    while (sent < 6 && budget < 50) begin
      cycle(1'b1, bpd[sent], 1'b1, mexp(bpd[sent]), acc);
      if (acc) sent++;
      budget++;
    end
    check("bp_accepts_all", sent, 6);
    drain();

    for (int i = 0; i < 2; i++) begin
      d = 24'($urandom);
      cycle(1'b1, d, 1'b0, mexp(d), acc);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    acc_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_z", z_a, 0);
    check("mid_rst_count", count_a, 0);
    repeat (4) cycle(1'b0, 24'($urandom), 1'b1, '0, acc);

    for (int i = 0; i < 400; i++) begin
      d = 24'($urandom);
      cycle(($urandom % 4) != 0, d, ($urandom % 3) != 0, mexp(d), acc);
      if (i % 50 == 0) check("count_rand", count_a, exp_count());
    end
    drain();
    check("count_after_rand", count_a, exp_count());
    check("count_oai", count_o, exp_count());

`ifdef LA_AOI_PIPE_COUNT_EN
    for (int i = 0; i < 70000; i++) begin
      d = 24'($urandom);
      cycle(1'b1, d, 1'b1, mexp(d), acc);
    end
    drain();
    check("count_saturated", count_a, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
